// File: rtl/read_manager_v3.sv
// -----------------------------------------------------------------------------
// read_manager_v3
//
// Read manager for the OFC event buffer. It counts complete events by
// collecting per-channel write-complete strobes against the enable mask. For
// each stored event it walks the shared ring RAM once per enabled channel,
// driving raddr / ren / read_input_id. It also provides downstream
// back-pressure, a diagnosis of which channels are missing when a partial event
// times out, and an occupancy count that stays correct when the counters wrap.
//
// Optional build macro:
//   SNOOZE_EN - when defined, a new event read starts only after at least
//               snooze_threshold idle clocks since the previous read_done.
//               When undefined, snooze_threshold is ignored.
//
// Ports:
//   clk                 system clock
//   rst_n               asynchronous active-low reset
//   live_rising         synchronous run restart (same effect as reset)
//   HALF_PACKAGE_LENGTH words per channel per event (>= 1)
//   MEMORY_DEPTH        ring depth in words (>= HALF_PACKAGE_LENGTH)
//   MAX_NEVENT          occupancy limit for buffer_full
//   input_ena           channel enable mask
//   w_complete          per-channel write-done strobes
//   snooze_threshold    idle clocks required between events (SNOOZE_EN only)
//   rd_ready            downstream accepts the current word
//   raddr/ren/read_input_id  RAM read address, read valid, channel being read
//   n_write/n_read      events fully written / fully read
//   occupancy           n_write - n_read (modulo 2^CNT_W)
//   read_done           one-cycle pulse at the end of each event read
//   timeout             sticky partial-event timeout
//   timeout_mask        enabled channels still missing at timeout
//   buffer_full         sticky overflow flag (occupancy > MAX_NEVENT)
// -----------------------------------------------------------------------------
module read_manager_v3 #(
    parameter int N_CH             = 16,
    parameter int CH_W             = $clog2(N_CH),
    parameter int ADDR_W           = 14,
    parameter int LEN_W            = 10,
    parameter int CNT_W            = 16,
    parameter int MAX_WAITING_TIME = 1000,
    parameter int TO_W             = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              live_rising,
    input  logic [LEN_W-1:0]  HALF_PACKAGE_LENGTH,
    input  logic [ADDR_W-1:0] MEMORY_DEPTH,
    input  logic [CNT_W-1:0]  MAX_NEVENT,
    input  logic [N_CH-1:0]   input_ena,
    input  logic [N_CH-1:0]   w_complete,
    input  logic [15:0]       snooze_threshold,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] raddr,
    output logic              ren,
    output logic [CH_W-1:0]   read_input_id,
    output logic [CNT_W-1:0]  n_write,
    output logic [CNT_W-1:0]  n_read,
    output logic [CNT_W-1:0]  occupancy,
    output logic              read_done,
    output logic              timeout,
    output logic [N_CH-1:0]   timeout_mask,
    output logic              buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, NEXT, DONE} state_t;

    state_t              state_q, state_d;
    logic [N_CH-1:0]     w_tag_q, w_tag_d;
    logic [N_CH-1:0]     ena_q, ena_d;
    logic [N_CH-1:0]     tmask_q, tmask_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic [ADDR_W-1:0]   init_q, init_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [CH_W-1:0]     id_q, id_d;
    logic                ren_q, ren_d;
    logic                done_q, done_d;
    logic                to_q, to_d;
    logic                full_q, full_d;
    logic [CNT_W-1:0]    nw_q, nw_d;
    logic [CNT_W-1:0]    nr_q, nr_d;
    logic [TO_W-1:0]     tcnt_q, tcnt_d;
    logic [15:0]         snz_q, snz_d;

    logic [N_CH-1:0]     tag;
    logic                ev_written;
    logic [CNT_W-1:0]    occ;
    logic [LEN_W:0]      cnt_inc;
    logic                last_word;
    logic [ADDR_W-1:0]   raddr_inc;
    logic [ADDR_W:0]     init_sum;
    logic [ADDR_W-1:0]   init_wrapped;
    logic [CH_W-1:0]     first_ch;
    logic [CH_W-1:0]     next_ch;
    logic                has_next;
    logic                snooze_ok;

    assign tag        = w_tag_q | (w_complete & input_ena);
    assign ev_written = (input_ena != '0) && (tag == input_ena);
    // Modular subtraction keeps occupancy right across counter wrap.
    assign occ        = nw_q - nr_q;
    assign cnt_inc    = {1'b0, cnt_q} + (LEN_W+1)'(1);
    assign last_word  = cnt_inc >= {1'b0, HALF_PACKAGE_LENGTH};
    assign raddr_inc  = (raddr_q == MEMORY_DEPTH - ADDR_W'(1)) ? '0 : raddr_q + ADDR_W'(1);
    // Ring wrap of the event base address without a modulo operator.
    assign init_sum     = {1'b0, init_q} + (ADDR_W+1)'(HALF_PACKAGE_LENGTH);
    assign init_wrapped = (init_sum >= {1'b0, MEMORY_DEPTH})
                          ? ADDR_W'(init_sum - {1'b0, MEMORY_DEPTH})
                          : ADDR_W'(init_sum);

`ifdef SNOOZE_EN
    assign snooze_ok = snz_q >= snooze_threshold;
`else
    logic unused_snooze;
    assign unused_snooze = ^snooze_threshold;
    assign snooze_ok     = 1'b1;
`endif

    // Lowest enabled channel of the live mask (used when an event read starts)
    // and the next higher enabled channel of the latched mask.
    always_comb begin
        first_ch = '0;
        next_ch  = '0;
        has_next = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (input_ena[i]) begin
                first_ch = CH_W'(i);
            end
            if (ena_q[i] && (i > int'(id_q))) begin
                next_ch  = CH_W'(i);
                has_next = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        raddr_d = raddr_q;
        ren_d   = ren_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        init_d  = init_q;
        ena_d   = ena_q;
        nr_d    = nr_q;
        done_d  = 1'b0;
        snz_d   = (snz_q == 16'hFFFF) ? snz_q : snz_q + 16'd1;
        to_d    = to_q;
        tmask_d = tmask_q;
        full_d  = full_q;

        // Write side
        nw_d    = ev_written ? nw_q + CNT_W'(1) : nw_q;
        w_tag_d = ev_written ? '0 : tag;

        // Partial-event timeout; counter saturates once past the limit
        if (w_tag_q == '0) begin
            tcnt_d = '0;
        end else if (tcnt_q <= TO_W'(MAX_WAITING_TIME)) begin
            tcnt_d = tcnt_q + TO_W'(1);
        end else begin
            tcnt_d = tcnt_q;
        end
        if (!to_q && (tcnt_q > TO_W'(MAX_WAITING_TIME))) begin
            to_d    = 1'b1;
            tmask_d = input_ena & ~w_tag_q;
        end

        if (occ > MAX_NEVENT) begin
            full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                ren_d = 1'b0;
                if (!to_q && (occ != '0) && snooze_ok) begin
                    state_d = READ;
                    raddr_d = init_q;
                    id_d    = first_ch;
                    cnt_d   = '0;
                    ren_d   = 1'b1;
                    ena_d   = input_ena;
                end
            end
            READ: begin
                if (ren_q && rd_ready) begin
                    if (!last_word) begin
                        cnt_d   = cnt_inc[LEN_W-1:0];
                        raddr_d = raddr_inc;
                    end else if (has_next) begin
                        state_d = NEXT;
                        ren_d   = 1'b0;
                    end else begin
                        state_d = DONE;
                        ren_d   = 1'b0;
                    end
                end
            end
            NEXT: begin
                state_d = READ;
                id_d    = next_ch;
                raddr_d = init_q;
                cnt_d   = '0;
                ren_d   = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                ren_d   = 1'b0;
                nr_d    = nr_q + CNT_W'(1);
                done_d  = 1'b1;
                init_d  = init_wrapped;
                snz_d   = '0;
            end
            default: begin
                state_d = IDLE;
                ren_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_tag_q <= '0;
            ena_q   <= '0;
            tmask_q <= '0;
            raddr_q <= '0;
            init_q  <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
            ren_q   <= 1'b0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
            full_q  <= 1'b0;
            nw_q    <= '0;
            nr_q    <= '0;
            tcnt_q  <= '0;
            snz_q   <= '1;
        end else if (live_rising) begin
            state_q <= IDLE;
            w_tag_q <= '0;
            ena_q   <= '0;
            tmask_q <= '0;
            raddr_q <= '0;
            init_q  <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
            ren_q   <= 1'b0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
            full_q  <= 1'b0;
            nw_q    <= '0;
            nr_q    <= '0;
            tcnt_q  <= '0;
            snz_q   <= '1;
        end else begin
            state_q <= state_d;
            w_tag_q <= w_tag_d;
            ena_q   <= ena_d;
            tmask_q <= tmask_d;
            raddr_q <= raddr_d;
            init_q  <= init_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            ren_q   <= ren_d;
            done_q  <= done_d;
            to_q    <= to_d;
            full_q  <= full_d;
            nw_q    <= nw_d;
            nr_q    <= nr_d;
            tcnt_q  <= tcnt_d;
            snz_q   <= snz_d;
        end
    end

    assign raddr         = raddr_q;
    assign ren           = ren_q;
    assign read_input_id = id_q;
    assign n_write       = nw_q;
    assign n_read        = nr_q;
    assign occupancy     = occ;
    assign read_done     = done_q;
    assign timeout       = to_q;
    assign timeout_mask  = tmask_q;
    assign buffer_full   = full_q;

endmodule
